// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which cache owns the current (or last) burst
//   DEF_LINE_WORDS / BEAT_W / OFFS_W : default line geometry
package mem_arb_pkg;

  localparam int unsigned DEF_LINE_WORDS = 8;
  localparam int unsigned BEAT_W         = $clog2(DEF_LINE_WORDS);
  localparam int unsigned OFFS_W         = BEAT_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    BURST_I,
    BURST_D
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the arbiter.
//   slave  : arbiter view (cache requests and memory responses in, grants/beats out)
//   master : environment view (caches + memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rvalid;
  logic [31:0]       ic_rdata;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_wnext;
  logic              dc_rvalid;
  logic [31:0]       dc_rdata;
  logic              dc_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    output ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    input  ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/burst_addr_gen.sv
// Beat counter and registered beat-address generator for one line burst.
//   CLK, RESET : clock, async active-high reset
//   i_start    : grant this cycle; latch line (upper) address, point at beat 0
//   i_ack      : beat completed this cycle
//   i_line_hi  : line address with offset bits removed
//   o_addr     : registered word-aligned beat address (0 when no burst)
//   o_last     : current beat is the final beat of the line
module burst_addr_gen
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  i_start,
  input  logic                                  i_ack,
  input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0]  i_line_hi,
  output logic [ADDR_W-1:0]                     o_addr,
  output logic                                  o_last
);
  localparam int unsigned L_BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned HI_W     = ADDR_W - L_BEAT_W - 2;

  logic [L_BEAT_W-1:0] r_beat;
  logic [HI_W-1:0]     r_line_hi;
  logic [ADDR_W-1:0]   r_addr;
  logic [L_BEAT_W-1:0] w_beat_nxt;

  assign w_beat_nxt = r_beat + 1'b1;
  assign o_last     = (r_beat == L_BEAT_W'(LINE_WORDS - 1));
  assign o_addr     = r_addr;

  // The counter is a power-of-2 width, so the final increment wraps it to 0 on exit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_beat    <= '0;
      r_line_hi <= '0;
      r_addr    <= '0;
    end else if (i_start) begin
      r_beat    <= '0;
      r_line_hi <= i_line_hi;
      r_addr    <= {i_line_hi, {L_BEAT_W{1'b0}}, 2'b00};
    end else if (i_ack) begin
      r_beat <= w_beat_nxt;
      r_addr <= o_last ? '0 : {r_line_hi, w_beat_nxt, 2'b00};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache fills and D-cache fills/write-backs.
// A grant is taken only in IDLE; the owner then gets an uninterruptible LINE_WORDS-beat
// burst, one word per mem_ack.
//   CLK, RESET : clock, async active-high reset
//   bus        : mem_port_arbiter_if.slave (cache requests, beat strobes, memory port, busy)
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise
// the D-cache always wins over the I-cache.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned ADDR_W     = 32
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned L_OFFS_W = $clog2(LINE_WORDS) + 2;

  state_e r_state;
  state_e w_state_d;
  logic   r_mem_req;
  logic   r_mem_we;
  logic   w_grant;
  owner_e w_pick;
  logic   w_ack;
  logic   w_last_beat;
  logic   w_done;
  logic   w_own_i;
  logic   w_own_d;
  logic   w_unused;
  logic [ADDR_W-1:0]          w_addr;
  logic [ADDR_W-L_OFFS_W-1:0] w_line_hi;

  assign w_unused = ^{bus.ic_addr[L_OFFS_W-1:0], bus.dc_addr[L_OFFS_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last_owner;

  always_comb begin
    if (bus.ic_req && bus.dc_req) begin
      w_pick = (r_last_owner == OWN_I) ? OWN_D : OWN_I;
    end else begin
      w_pick = bus.dc_req ? OWN_D : OWN_I;
    end
  end

  // Reset value I makes D win the first contention.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last_owner <= OWN_I;
    end else if (w_grant) begin
      r_last_owner <= w_pick;
    end
  end
`else
  assign w_pick = bus.dc_req ? OWN_D : OWN_I;
`endif

  // Acks outside a burst (mem_req low) are ignored entirely.
  assign w_ack  = bus.mem_ack & r_mem_req;
  assign w_done = w_ack & w_last_beat;

  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          w_grant   = 1'b1;
          w_state_d = (w_pick == OWN_D) ? BURST_D : BURST_I;
        end
      end
      BURST_I, BURST_D: begin
        if (w_done) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= (w_pick == OWN_D) & bus.dc_we;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign w_line_hi = (w_pick == OWN_D) ? bus.dc_addr[ADDR_W-1:L_OFFS_W]
                                       : bus.ic_addr[ADDR_W-1:L_OFFS_W];

  burst_addr_gen #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_start   (w_grant),
    .i_ack     (w_ack),
    .i_line_hi (w_line_hi),
    .o_addr    (w_addr),
    .o_last    (w_last_beat)
  );

  assign w_own_i = (r_state == BURST_I);
  assign w_own_d = (r_state == BURST_D);

  assign bus.ic_rvalid = w_own_i & w_ack;
  assign bus.ic_rdata  = w_own_i ? bus.mem_rdata : 32'h0;
  assign bus.ic_done   = w_own_i & w_done;
  assign bus.dc_rvalid = w_own_d & ~r_mem_we & w_ack;
  assign bus.dc_rdata  = (w_own_d & ~r_mem_we) ? bus.mem_rdata : 32'h0;
  assign bus.dc_wnext  = w_own_d & r_mem_we & w_ack;
  assign bus.dc_done   = w_own_d & w_done;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = (w_own_d & r_mem_we) ? bus.dc_wdata : 32'h0;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned LW = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .LINE_WORDS (LW),
    .ADDR_W     (32)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  owner_e m_last = OWN_I;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Arbitration rule from the specification.
  function automatic owner_e pick(input logic ic, input logic dc, input owner_e last);
`ifdef ARB_ROUND_ROBIN_EN
    if (ic && dc) return (last == OWN_I) ? OWN_D : OWN_I;
`endif
    return dc ? OWN_D : OWN_I;
  endfunction

  // {mem_req, mem_we, busy, ic_rvalid, ic_done, dc_rvalid, dc_wnext, dc_done}
  function automatic logic [7:0] ctrl();
    return {bus.mem_req, bus.mem_we, bus.busy, bus.ic_rvalid, bus.ic_done,
            bus.dc_rvalid, bus.dc_wnext, bus.dc_done};
  endfunction

  // Entered just after a rising edge with the DUT in IDLE and requests applied.
  // ack_pct < 0 means ack on every other cycle. raise_at: beat index at which the
  // non-owner raises its request. abort_at: return at the start of that beat.
  task automatic run_burst(input int ack_pct, input int raise_at, input bit keep,
                           input int abort_at);
    owner_e      own;
    logic [31:0] base;
    logic        we;
    logic        ack;
    logic        last;
    int          k;
    int          cyc;
    logic [7:0]  exp_c;
    own    = pick(bus.ic_req, bus.dc_req, m_last);
    m_last = own;
    base   = ((own == OWN_D) ? bus.dc_addr : bus.ic_addr) & ~32'(LW * 4 - 1);
    we     = (own == OWN_D) && bus.dc_we;
    bus.mem_ack = 1'b0;
    #3;
    chk("idle_ctrl", ctrl(), 8'h00);
    k   = 0;
    cyc = 0;
    while (k < LW) begin
      tick();
      if (k == abort_at) return;
      cyc++;
      ack = (ack_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < ack_pct);
      bus.mem_ack   = ack;
      bus.mem_rdata = $urandom;
      bus.dc_wdata  = $urandom;
      // Owner's address moves mid-burst; the latched line must be used.
      if (own == OWN_D) bus.dc_addr = $urandom;
      else bus.ic_addr = $urandom;
      if (k == raise_at) begin
        if (own == OWN_D) bus.ic_req = 1'b1;
        else bus.dc_req = 1'b1;
      end
      #3;
      last  = (k == LW - 1);
      exp_c = {1'b1, we, 1'b1,
               (own == OWN_I) && ack, (own == OWN_I) && ack && last,
               (own == OWN_D) && !we && ack, (own == OWN_D) && we && ack,
               (own == OWN_D) && ack && last};
      chk("beat_ctrl", ctrl(), exp_c);
      chk("beat_addr", bus.mem_addr, base + 32'(4 * k));
      chk("beat_wdata", bus.mem_wdata, we ? bus.dc_wdata : 32'h0);
      if (ack && own == OWN_I) chk("ic_rdata", bus.ic_rdata, bus.mem_rdata);
      if (ack && own == OWN_D && !we) chk("dc_rdata", bus.dc_rdata, bus.mem_rdata);
      if (ack) k++;
    end
    tick();
    bus.mem_ack = 1'b0;
    if (!keep) begin
      if (own == OWN_D) bus.dc_req = 1'b0;
      else bus.ic_req = 1'b0;
    end
  endtask

  initial begin
    RESET         = 1'b1;
    bus.ic_req    = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_req    = 1'b0;
    bus.dc_we     = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.mem_rdata = 32'hdead_beef;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    #3;
    chk("reset_ctrl", ctrl(), 8'h00);
    chk("reset_addr", bus.mem_addr, 32'h0);
    chk("reset_ic_rdata", bus.ic_rdata, 32'h0);
    tick();
    RESET = 1'b0;

    // 1: lone I fill, ack every cycle
    bus.ic_addr = 32'h0000_1234;
    bus.ic_req  = 1'b1;
    run_burst(100, -1, 1'b0, -1);

    // 2: D write-back, ack every other cycle
    bus.dc_we   = 1'b1;
    bus.dc_addr = 32'h8000_0040;
    bus.dc_req  = 1'b1;
    run_burst(-1, -1, 1'b0, -1);

    // 3: simultaneous requests, D keeps requesting after its first burst
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h0000_4000;
    bus.ic_addr = 32'h0000_2000;
    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    run_burst(100, -1, 1'b1, -1);
    run_burst(100, -1, 1'b0, -1);
    if (bus.ic_req || bus.dc_req) run_burst(100, -1, 1'b0, -1);

    // 4: I request arrives during beat 3 of a D fill
    bus.dc_addr = 32'h0000_6660;
    bus.ic_addr = 32'h0000_7770;
    bus.dc_req  = 1'b1;
    run_burst(100, 3, 1'b0, -1);
    run_burst(100, -1, 1'b0, -1);

    // 5: reset at beat 5 of an I fill, then a fresh request from beat 0
    bus.ic_addr = 32'h0001_0000;
    bus.ic_req  = 1'b1;
    run_burst(100, -1, 1'b0, 5);
    RESET         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #3;
    chk("midreset_ctrl", ctrl(), 8'h00);
    chk("midreset_addr", bus.mem_addr, 32'h0);
    chk("midreset_ic_rdata", bus.ic_rdata, 32'h0);
    tick();
    RESET       = 1'b0;
    bus.mem_ack = 1'b0;
    m_last      = OWN_I;
    bus.ic_addr = 32'h0002_0018;
    run_burst(100, -1, 1'b0, -1);

    // 6: spurious acks in IDLE
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
      #3;
      chk("spurious_ctrl", ctrl(), 8'h00);
      chk("spurious_addr", bus.mem_addr, 32'h0);
    end
    tick();
    bus.mem_ack = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      if (!bus.dc_req && $urandom_range(1) == 1) begin
        bus.dc_we   = 1'($urandom_range(1));
        bus.dc_addr = $urandom;
        bus.dc_req  = 1'b1;
      end
      if (!bus.ic_req && $urandom_range(1) == 1) begin
        bus.ic_addr = $urandom;
        bus.ic_req  = 1'b1;
      end
      if (!bus.ic_req && !bus.dc_req) bus.ic_req = 1'b1;
      run_burst(int'($urandom_range(100, 30)), int'($urandom_range(9)) - 1, 1'b0, -1);
    end

    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
